// File: rtl/image_write_pkg.sv
// Shared definitions for the BMP image source/sink pair: image geometry defaults,
// FSM encoding, pixel-pair payload and the BMP header byte generator.
package image_write_pkg;

  localparam int unsigned IMG_WIDTH     = 768;
  localparam int unsigned IMG_HEIGHT    = 512;
  localparam int unsigned BMP_HDR_BYTES = 54;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_HEADER  = 2'd1,
    ST_BODY    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] g0;
    logic [7:0] b0;
    logic [7:0] r1;
    logic [7:0] g1;
    logic [7:0] b1;
  } pix_pair_t;

  // Byte idx of a 24-bit uncompressed BMP header; all multi-byte fields little-endian.
  function automatic logic [7:0] bmp_hdr_byte(input int unsigned idx,
                                              input int unsigned w,
                                              input int unsigned h);
    int unsigned img_sz;
    int unsigned field;
    int unsigned base;
    img_sz = w * h * 3;
    field  = 0;
    base   = idx;
    if (idx == 0) return 8'h42;
    if (idx == 1) return 8'h4D;
    if (idx >= 2 && idx <= 5) begin
      field = BMP_HDR_BYTES + img_sz; base = 2;
    end else if (idx >= 10 && idx <= 13) begin
      field = BMP_HDR_BYTES; base = 10;
    end else if (idx >= 14 && idx <= 17) begin
      field = 40; base = 14;
    end else if (idx >= 18 && idx <= 21) begin
      field = w; base = 18;
    end else if (idx >= 22 && idx <= 25) begin
      field = h; base = 22;
    end else if (idx >= 26 && idx <= 27) begin
      field = 1; base = 26;
    end else if (idx >= 28 && idx <= 29) begin
      field = 24; base = 28;
    end else if (idx >= 34 && idx <= 37) begin
      field = img_sz; base = 34;
    end
    return 8'(field >> (8 * (idx - base)));
  endfunction

endpackage

// File: rtl/image_write_if.sv
// Byte-stream valid/ready link carrying the finished BMP file out of image_write.
interface image_write_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/bmp_frame_buf.sv
// Byte-wide frame store: one 6-byte pixel-pair write per clock, asynchronous byte read.
module bmp_frame_buf
  import image_write_pkg::*;
#(
  parameter  int unsigned DEPTH = 24,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          HCLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pix_pair_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data_c
);

  logic [7:0] mem [DEPTH];

  // Pair lands as R0 G0 B0 R1 G1 B1 at consecutive addresses
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem[wr_addr]          <= wr_data.r0;
      mem[wr_addr + AW'(1)] <= wr_data.g0;
      mem[wr_addr + AW'(2)] <= wr_data.b0;
      mem[wr_addr + AW'(3)] <= wr_data.r1;
      mem[wr_addr + AW'(4)] <= wr_data.g1;
      mem[wr_addr + AW'(5)] <= wr_data.b1;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/image_write.sv
// Frame sink: captures HSYNC-qualified pixel pairs bottom-up into a frame buffer,
// then streams the complete 24-bit BMP file (header + pixels) over valid/ready.
module image_write
  import image_write_pkg::*;
#(
  parameter int unsigned WIDTH     = IMG_WIDTH,
  parameter int unsigned HEIGHT    = IMG_HEIGHT,
  parameter int unsigned HDR_BYTES = BMP_HDR_BYTES
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  image_write_if.master bs,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned FB_BYTES = WIDTH * HEIGHT * 3;
  localparam int unsigned FAW      = (FB_BYTES > 1) ? $clog2(FB_BYTES) : 1;
  localparam int unsigned HAW      = $clog2(HDR_BYTES);
  localparam int unsigned BW       = (FAW > HAW) ? FAW : HAW;
  localparam int unsigned RW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW       = $clog2(WIDTH);

  state_t       state;
  state_t       next_state;
  logic         vsync_d;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [BW-1:0] bcnt;

  logic         vsync_rise;
  logic         cap_fire;
  logic         row_end;
  logic         frame_end;
  logic         hshake;
  logic         hdr_end;
  logic         body_end;
  logic [BW-1:0] wr_base;
  pix_pair_t    pix;
  logic [7:0]   fb_rd;

  logic         out_valid_c;
  logic [7:0]   out_data_c;
  logic         out_last_c;
  logic         done_c;

  assign vsync_rise = VSYNC & ~vsync_d;
  // A VSYNC restart wins over a pair arriving in the same cycle
  assign cap_fire   = (state == ST_CAPTURE) & HSYNC & ~vsync_rise;
  assign row_end    = (col == CW'(WIDTH - 2));
  assign frame_end  = cap_fire & row_end & (row == RW'(HEIGHT - 1));
  assign hshake     = out_valid_c & bs.out_ready;
  assign hdr_end    = (bcnt == BW'(HDR_BYTES - 1));
  assign body_end   = (bcnt == BW'(FB_BYTES - 1));

  // BMP rows are stored bottom-up: first captured row is the last row in the file
  assign wr_base = BW'(WIDTH * 3) * (BW'(HEIGHT - 1) - BW'(row)) + BW'(3) * BW'(col);
  assign pix     = '{r0: DATA_R0, g0: DATA_G0, b0: DATA_B0,
                     r1: DATA_R1, g1: DATA_G1, b1: DATA_B1};

  bmp_frame_buf #(.DEPTH(FB_BYTES)) u_fb (
    .HCLK      (HCLK),
    .wr_en     (cap_fire),
    .wr_addr   (FAW'(wr_base)),
    .wr_data   (pix),
    .rd_addr   (FAW'(bcnt)),
    .rd_data_c (fb_rd)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_CAPTURE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CAPTURE: if (frame_end)          next_state = ST_HEADER;
      ST_HEADER:  if (hshake && hdr_end)  next_state = ST_BODY;
      ST_BODY:    if (hshake && body_end) next_state = ST_DONE;
      ST_DONE:    if (vsync_rise)         next_state = ST_CAPTURE;
      default:                            next_state = ST_CAPTURE;
    endcase
  end

  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = 8'h00;
    out_last_c  = 1'b0;
    done_c      = 1'b0;
    case (state)
      ST_HEADER: begin
        out_valid_c = 1'b1;
        out_data_c  = bmp_hdr_byte(32'(bcnt), WIDTH, HEIGHT);
      end
      ST_BODY: begin
        out_valid_c = 1'b1;
        out_data_c  = fb_rd;
        out_last_c  = body_end;
      end
      ST_DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  assign bs.out_valid = out_valid_c;
  assign bs.out_data  = out_data_c;
  assign bs.out_last  = out_last_c;
  assign frame_done   = done_c;

  // Capture position, stream byte counter, VSYNC edge history and sticky overrun
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vsync_d <= 1'b0;
      overrun <= 1'b0;
      row     <= '0;
      col     <= '0;
      bcnt    <= '0;
    end else begin
      vsync_d <= VSYNC;
      if (HSYNC && (state != ST_CAPTURE)) overrun <= 1'b1;
      case (state)
        ST_CAPTURE: begin
          bcnt <= '0;
          if (vsync_rise) begin
            row <= '0;
            col <= '0;
          end else if (cap_fire) begin
            if (row_end) begin
              col <= '0;
              row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(2);
            end
          end
        end
        ST_HEADER: if (hshake) bcnt <= hdr_end ? '0 : bcnt + BW'(1);
        ST_BODY:   if (hshake) bcnt <= body_end ? '0 : bcnt + BW'(1);
        ST_DONE: begin
          if (vsync_rise) begin
            row  <= '0;
            col  <= '0;
            bcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_write.sv
// Self-checking bench for image_write at 4x2: a file-level BMP model predicts the
// byte stream, which a negedge monitor compares byte by byte.
module tb_image_write;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 54;
  localparam int FB = W * H * 3;
  localparam int NB = HB + FB;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       VSYNC = 1'b0;
  logic       HSYNC = 1'b0;
  logic [7:0] r0 = 8'h00, g0 = 8'h00, b0 = 8'h00;
  logic [7:0] r1 = 8'h00, g1 = 8'h00, b1 = 8'h00;
  logic       frame_done;
  logic       overrun;

  image_write_if bs();

  image_write #(.WIDTH(W), .HEIGHT(H), .HDR_BYTES(HB)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .VSYNC      (VSYNC),
    .HSYNC      (HSYNC),
    .DATA_R0    (r0),
    .DATA_G0    (g0),
    .DATA_B0    (b0),
    .DATA_R1    (r1),
    .DATA_G1    (g1),
    .DATA_B1    (b1),
    .bs         (bs),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 HCLK = ~HCLK;

  int         passed = 0;
  int         total  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx[128];
  int         rx_cnt = 0;
  int         last_idx = -1;
  bit         stalled = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;
  bit         rdy_random = 1'b0;
  logic [7:0] hdr_m[HB];
  logic [7:0] fb_m[FB];
  logic [7:0] pr[W*H], pg[W*H], pb[W*H];
  logic [7:0] body_a[FB];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic put_le(input int ofs, input int nbytes, input int unsigned v);
    for (int i = 0; i < nbytes; i++) hdr_m[ofs + i] = 8'(v >> (8 * i));
  endtask

  task automatic build_hdr();
    for (int i = 0; i < HB; i++) hdr_m[i] = 8'h00;
    hdr_m[0] = 8'h42;
    hdr_m[1] = 8'h4D;
    put_le(2, 4, HB + FB);
    put_le(10, 4, HB);
    put_le(14, 4, 40);
    put_le(18, 4, W);
    put_le(22, 4, H);
    put_le(26, 2, 1);
    put_le(28, 2, 24);
    put_le(34, 4, FB);
  endtask

  // One sample per cycle at the negedge: a handshake there completes at the next posedge
  task automatic monitor_step();
    if (!HRESETn) begin
      stalled = 1'b0;
    end else if (bs.out_valid) begin
      if (stalled) begin
        check(bs.out_data == stall_data, "stall_data_stable", int'(bs.out_data), int'(stall_data));
        check(bs.out_last == stall_last, "stall_last_stable", int'(bs.out_last), int'(stall_last));
      end
      if (bs.out_ready) begin
        check(exp_q.size() != 0, "extra_byte", rx_cnt, NB);
        if (exp_q.size() != 0) begin
          check(bs.out_data == exp_q[0], "stream_byte", int'(bs.out_data), int'(exp_q[0]));
          check(bs.out_last == (exp_q.size() == 1), "out_last", int'(bs.out_last),
                int'(exp_q.size() == 1));
          void'(exp_q.pop_front());
        end
        if (bs.out_last) last_idx = rx_cnt;
        if (rx_cnt < 128) rx[rx_cnt] = bs.out_data;
        rx_cnt++;
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        stall_data = bs.out_data;
        stall_last = bs.out_last;
      end
    end else begin
      stalled = 1'b0;
    end
  endtask

  // Drives one frame of pairs (optional random HSYNC gaps) after loading the model
  task automatic capture(input int gap_max, input bit rnd);
    int rw, cl, off;
    for (int p = 0; p < W * H; p++) begin
      pr[p] = rnd ? 8'($urandom) : 8'(p);
      pg[p] = rnd ? 8'($urandom) : 8'(p);
      pb[p] = rnd ? 8'($urandom) : 8'(p);
      rw = p / W;
      cl = p % W;
      off = (H - 1 - rw) * W * 3 + cl * 3;
      fb_m[off]     = pr[p];
      fb_m[off + 1] = pg[p];
      fb_m[off + 2] = pb[p];
    end
    exp_q.delete();
    for (int i = 0; i < HB; i++) exp_q.push_back(hdr_m[i]);
    for (int i = 0; i < FB; i++) exp_q.push_back(fb_m[i]);
    rx_cnt   = 0;
    last_idx = -1;
    for (int k = 0; k < W * H / 2; k++) begin
      repeat ($urandom_range(gap_max)) begin
        HSYNC = 1'b0;
        @(posedge HCLK); #1;
      end
      HSYNC = 1'b1;
      r0 = pr[2*k];   g0 = pg[2*k];   b0 = pb[2*k];
      r1 = pr[2*k+1]; g1 = pg[2*k+1]; b1 = pb[2*k+1];
      @(posedge HCLK); #1;
    end
    HSYNC = 1'b0;
    check(bs.out_valid == 1'b1, "valid_after_capture", int'(bs.out_valid), 1);
    check(bs.out_data == 8'h42, "first_byte", int'(bs.out_data), 'h42);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 1000) begin
      @(negedge HCLK); #1;
      n++;
    end
    check(frame_done == 1'b1, "frame_done_timeout", int'(frame_done), 1);
    check(rx_cnt == NB, "byte_count", rx_cnt, NB);
    check(exp_q.size() == 0, "missing_bytes", exp_q.size(), 0);
    check(last_idx == NB - 1, "last_index", last_idx, NB - 1);
    check(bs.out_valid == 1'b0, "valid_in_done", int'(bs.out_valid), 0);
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_cnt < target && n < 500) begin
      @(negedge HCLK); #1;
      n++;
    end
    check(rx_cnt >= target, "rx_progress_timeout", rx_cnt, target);
  endtask

  task automatic vsync_pulse(input bit chk_done);
    @(posedge HCLK); #1;
    VSYNC = 1'b1;
    @(posedge HCLK); #1;
    VSYNC = 1'b0;
    if (chk_done) check(frame_done == 1'b0, "frame_done_clear", int'(frame_done), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(bs.out_valid == 1'b0, {tag, "_out_valid"}, int'(bs.out_valid), 0);
    check(bs.out_data == 8'h00, {tag, "_out_data"}, int'(bs.out_data), 0);
    check(bs.out_last == 1'b0, {tag, "_out_last"}, int'(bs.out_last), 0);
    check(frame_done == 1'b0, {tag, "_frame_done"}, int'(frame_done), 0);
    check(overrun == 1'b0, {tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int bad;
    build_hdr();
    fork
      forever begin
        @(negedge HCLK);
        monitor_step();
      end
      begin
        bs.out_ready = 1'b1;
        forever begin
          @(posedge HCLK); #1;
          bs.out_ready = rdy_random ? 1'($urandom_range(1)) : 1'b1;
        end
      end
    join_none

    #3;
    check_outputs_zero("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Frame A: pixel value = index, back-to-back pairs, consumer always ready
    @(posedge HCLK); #1;
    capture(0, 1'b0);
    wait_done();
    check(rx[0] == 8'h42, "hdr_B", int'(rx[0]), 'h42);
    check(rx[1] == 8'h4D, "hdr_M", int'(rx[1]), 'h4D);
    check(rx[2] == 8'h4E, "hdr_filesize0", int'(rx[2]), 'h4E);
    check(rx[3] == 8'h00, "hdr_filesize1", int'(rx[3]), 0);
    check(rx[10] == 8'd54, "hdr_offset", int'(rx[10]), 54);
    check(rx[14] == 8'd40, "hdr_dib", int'(rx[14]), 40);
    check(rx[18] == 8'd4, "hdr_width", int'(rx[18]), 4);
    check(rx[22] == 8'd2, "hdr_height", int'(rx[22]), 2);
    check(rx[26] == 8'd1, "hdr_planes", int'(rx[26]), 1);
    check(rx[28] == 8'd24, "hdr_bpp", int'(rx[28]), 24);
    check(rx[34] == 8'd24, "hdr_imgsize", int'(rx[34]), 24);
    check(rx[54] == 8'd4, "body_row1_first", int'(rx[54]), 4);
    check(rx[57] == 8'd5, "body_row1_px5", int'(rx[57]), 5);
    check(rx[66] == 8'd0, "body_row0_first", int'(rx[66]), 0);
    check(rx[77] == 8'd3, "body_last_byte", int'(rx[77]), 3);
    for (int i = 0; i < FB; i++) body_a[i] = rx[HB + i];

    // Frame B: same pixels with HSYNC gaps, stalling consumer
    vsync_pulse(1'b1);
    rdy_random = 1'b1;
    capture(3, 1'b0);
    wait_done();
    bad = 0;
    for (int i = 0; i < FB; i++) if (rx[HB + i] != body_a[i]) bad++;
    check(bad == 0, "body_vs_gapfree", bad, 0);
    check(overrun == 1'b0, "no_overrun_yet", int'(overrun), 0);

    // Frame C: new random pixels, HSYNC injected during the body
    vsync_pulse(1'b1);
    capture(2, 1'b1);
    wait_rx(60);
    @(posedge HCLK); #1;
    HSYNC = 1'b1;
    r0 = 8'hEE; g0 = 8'hEE; b0 = 8'hEE; r1 = 8'hEE; g1 = 8'hEE; b1 = 8'hEE;
    repeat (3) begin
      @(posedge HCLK); #1;
    end
    HSYNC = 1'b0;
    @(negedge HCLK); #1;
    check(overrun == 1'b1, "overrun_set", int'(overrun), 1);
    wait_done();
    check(overrun == 1'b1, "overrun_sticky", int'(overrun), 1);

    // Frame D: reset in the middle of the body, then a fresh frame
    vsync_pulse(1'b1);
    rdy_random = 1'b0;
    capture(1, 1'b1);
    wait_rx(HB + 10);
    HRESETn = 1'b0;
    #1;
    check_outputs_zero("midstream_reset");
    exp_q.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    // Partial frame discarded by a VSYNC restart before the real one
    HSYNC = 1'b1;
    r0 = 8'h11; g0 = 8'h22; b0 = 8'h33; r1 = 8'h44; g1 = 8'h55; b1 = 8'h66;
    repeat (2) begin
      @(posedge HCLK); #1;
    end
    HSYNC = 1'b0;
    vsync_pulse(1'b0);
    rdy_random = 1'b1;
    capture(2, 1'b1);
    wait_done();
    check(rx[0] == 8'h42, "after_reset_first", int'(rx[0]), 'h42);
    check(overrun == 1'b0, "overrun_cleared_by_reset", int'(overrun), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
